mem_cmd_sequencer: RTL and testbench

Command front-end placed directly upstream of `mem` on `mem_interface`: accepts read/write requests over a valid/ready stream, buffers them in a small in-order FIFO, and sequences them onto the memory's single-cycle `write`/`read` strobes. Read data is returned on a response channel with backpressure. Replaces ad-hoc `write_mem`/`read_mem` task driving once the memory is used by RTL masters rather than the bench.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_cmd_fifo.sv | 54 +++++
 rtl/mem_cmd_sequencer.sv | 120 ++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`timescale 1ns/1ps
// Shared types for the memory command path: default widths, the queued
// command record and the sequencer state encoding.
package mem_pkg;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 16;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      WAIT,
      RESP
   } seq_state_e;

endpackage

// File: rtl/mem_cmd_fifo.sv
`timescale 1ns/1ps
// In-order synchronous command FIFO. Push is ignored when full, pop is
// ignored when empty; simultaneous push and pop keep occupancy unchanged.
import mem_pkg::*;

module mem_cmd_fifo #(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = mem_cmd_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  entry_t din,
   output entry_t head,
   output logic   full,
   output logic   empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   entry_t           store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = store[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
         else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied.
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_cmd_sequencer.sv
`timescale 1ns/1ps
// Memory command front-end: queues read/write requests and issues them one
// at a time as single-cycle strobes, returning read data with backpressure.
import mem_pkg::*;

module mem_cmd_sequencer #(
   parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
   parameter int unsigned DATA_W     = mem_pkg::DATA_W,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic              busy
);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   seq_state_e        state;
   seq_state_e        state_nxt;
   cmd_t              req_cmd;
   cmd_t              head_cmd;
   cmd_t              cmd_q;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] rsp_addr_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   assign req_cmd   = '{write: req_write, addr: req_addr, wdata: req_wdata};
   assign req_ready = !fifo_full;
   assign push      = req_valid && req_ready;

   mem_cmd_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (cmd_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (req_cmd),
      .head  (head_cmd),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state, pop and strobe decode; strobes depend on registered state only.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      mem_write = 1'b0;
      mem_read  = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               state_nxt = head_cmd.write ? WR : RD;
            end
         end
         WR: begin
            mem_write = 1'b1;
            state_nxt = IDLE;
         end
         RD: begin
            mem_read  = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, command and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cmd_q       <= '0;
         rsp_addr_q  <= '0;
         rsp_rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (pop) cmd_q <= head_cmd;
         if (state == WAIT) begin
            rsp_addr_q  <= cmd_q.addr;
            rsp_rdata_q <= mem_data_out;
         end
      end
   end

   assign mem_addr    = cmd_q.addr;
   assign mem_data_in = cmd_q.wdata;
   assign rsp_addr    = rsp_addr_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign busy        = !fifo_empty || (state != IDLE);

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
`timescale 1ns/1ps
// Bench for mem_cmd_sequencer: memory stand-in, reference model of request
// ordering/read-after-write semantics, directed and randomized steps.
module tb_mem_cmd_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_addr;
   logic [15:0] rsp_rdata;
   logic [7:0]  mem_addr;
   logic [15:0] mem_data_in;
   logic        mem_write;
   logic        mem_read;
   logic [15:0] mem_data_out;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int wr_strobes = 0;
   int rd_strobes = 0;
   int rsp_cycles = 0;
   int rsp_count = 0;
   logic [15:0] last_rdata = '0;
   bit rand_rsp = 0;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [15:0] ref_mem [logic [7:0]];

   logic [15:0] mem_arr [256];
   bit          written [256];
   logic [15:0] rd_q = '0;

   mem_cmd_sequencer #(
      .ADDR_W     (8),
      .DATA_W     (16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_addr     (rsp_addr),
      .rsp_rdata    (rsp_rdata),
      .mem_addr     (mem_addr),
      .mem_data_in  (mem_data_in),
      .mem_write    (mem_write),
      .mem_read     (mem_read),
      .mem_data_out (mem_data_out),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Power-up content of the memory; 0x20 is preloaded with a known word.
   function automatic logic [15:0] init_val(input logic [7:0] a);
      if (a == 8'h20) return 16'hABCD;
      return {a, ~a} ^ 16'h5A5A;
   endfunction

   function automatic logic [15:0] rd_ref(input logic [7:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction

   // Memory stand-in: writes on the strobe edge, read data valid the cycle after.
   always @(posedge clk) begin
      if (mem_write) begin
         mem_arr[mem_addr] <= mem_data_in;
         written[mem_addr] <= 1'b1;
      end
      if (mem_read) rd_q <= written[mem_addr] ? mem_arr[mem_addr] : init_val(mem_addr);
   end
   assign mem_data_out = rd_q;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle monitor: strobe exclusivity and in-order response scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_write || mem_read) chk("strobe_excl", 32'(mem_write & mem_read), 32'd0);
         if (mem_write) wr_strobes++;
         if (mem_read)  rd_strobes++;
         if (rsp_valid) rsp_cycles++;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rsp_addr", 32'(rsp_addr), 32'(mon_e.addr));
               chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.data));
               last_rdata = rsp_rdata;
               rsp_count++;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_req(input bit w, input logic [7:0] a, input logic [15:0] d);
      bit ok;
      int n;
      n = 0;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      do begin
         ok = req_ready;
         if (rand_rsp) rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
         n++;
      end while (!ok && n < 300);
      req_valid = 1'b0;
      chk("push_accept", 32'(ok), 32'd1);
      if (ok) begin
         if (w) ref_mem[a] = d;
         else   exp_q.push_back('{addr: a, data: rd_ref(a)});
      end
   endtask

   task automatic drain;
      int n;
      n = 0;
      rsp_ready = 1'b1;
      while ((exp_q.size() != 0 || busy) && n < 500) begin
         tick();
         n++;
      end
      chk("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
   endtask

   initial begin
      int w0;
      int s0;
      int r0;
      int c0;
      int nreads;
      int n;
      bit w;
      logic [15:0] d;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_addr", 32'(rsp_addr), 32'd0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // Write 0x10 <- 0x1234 with exact strobe timing, then read it back.
      rsp_ready = 1'b1;
      w0 = wr_strobes;
      push_req(1'b1, 8'h10, 16'h1234);
      chk("wr_n_strobe", 32'(mem_write), 32'd0);
      chk("wr_n_busy", 32'(busy), 32'd1);
      tick();
      chk("wr_n1_strobe", 32'(mem_write), 32'd1);
      chk("wr_n1_addr", 32'(mem_addr), 32'h10);
      chk("wr_n1_data", 32'(mem_data_in), 32'h1234);
      tick();
      chk("wr_n2_strobe", 32'(mem_write), 32'd0);
      chk("wr_pulse_len", 32'(wr_strobes - w0), 32'd1);
      chk("wr_idle_busy", 32'(busy), 32'd0);
      push_req(1'b0, 8'h10, 16'h0);
      chk("rd_n_rsp", 32'(rsp_valid), 32'd0);
      tick();
      chk("rd_n1_strobe", 32'(mem_read), 32'd1);
      chk("rd_n1_addr", 32'(mem_addr), 32'h10);
      tick();
      chk("rd_n2_strobe", 32'(mem_read), 32'd0);
      chk("rd_n2_rsp", 32'(rsp_valid), 32'd0);
      tick();
      chk("rd_n3_rsp", 32'(rsp_valid), 32'd1);
      chk("rd_n3_addr", 32'(rsp_addr), 32'h10);
      chk("rd_n3_data", 32'(rsp_rdata), 32'h1234);
      tick();
      chk("rd_n4_rsp", 32'(rsp_valid), 32'd0);

      // Six requests behind a stalled read: FIFO fills at four entries.
      rsp_ready = 1'b0;
      r0 = rsp_count;
      nreads = 1;
      push_req(1'b0, 8'h00, 16'h0);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) rsp_ready = 1'b1;
         w = 1'($urandom_range(0, 1));
         if (!w) nreads++;
         push_req(w, 8'($urandom_range(8'h30, 8'h33)), 16'($urandom));
         if (i == 2) chk("fifo_not_full_3", 32'(req_ready), 32'd1);
         if (i == 3) begin
            chk("fifo_full_4", 32'(req_ready), 32'd0);
            chk("fifo_full_busy", 32'(busy), 32'd1);
         end
      end
      drain();
      chk("burst_rsp_count", 32'(rsp_count - r0), 32'(nreads));

      // Response backpressure on a preloaded location.
      rsp_ready = 1'b0;
      push_req(1'b0, 8'h20, 16'h0);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
      chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
      s0 = wr_strobes + rd_strobes;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
         chk("bp_hold_data", 32'(rsp_rdata), 32'hABCD);
         chk("bp_hold_addr", 32'(rsp_addr), 32'h20);
      end
      chk("bp_no_strobes", 32'(wr_strobes + rd_strobes - s0), 32'd0);
      rsp_ready = 1'b1;
      tick();
      chk("bp_release", 32'(rsp_valid), 32'd0);

      // Alternating write/read on the top address.
      for (int i = 0; i < 4; i++) begin
         d = 16'($urandom);
         if (i == 0) d = 16'hBEEF;
         push_req(1'b1, 8'hFF, d);
         push_req(1'b0, 8'hFF, 16'h0);
         drain();
         chk("alt_readback", 32'(last_rdata), 32'(d));
      end

      // Randomized traffic with random response backpressure.
      rand_rsp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, 9);
         push_req(1'($urandom_range(0, 1)),
                  (n == 8) ? 8'h00 : (n == 9) ? 8'hFF : 8'(8'h30 + n),
                  16'($urandom));
      end
      rand_rsp = 1'b0;
      drain();

      // Reset while a read is in WAIT with two reads still queued.
      rsp_ready = 1'b1;
      push_req(1'b0, 8'h31, 16'h0);
      push_req(1'b0, 8'h32, 16'h0);
      push_req(1'b0, 8'h33, 16'h0);
      chk("flush_pre_busy", 32'(busy), 32'd1);
      chk("flush_pre_rsp", 32'(rsp_valid), 32'd0);
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("flush_mem_write", 32'(mem_write), 32'd0);
      chk("flush_mem_read", 32'(mem_read), 32'd0);
      chk("flush_req_ready", 32'(req_ready), 32'd1);
      rst_n = 1'b1;
      s0 = wr_strobes + rd_strobes;
      c0 = rsp_cycles;
      repeat (20) tick();
      chk("flush_no_strobes", 32'(wr_strobes + rd_strobes - s0), 32'd0);
      chk("flush_no_rsp", 32'(rsp_cycles - c0), 32'd0);
      chk("flush_idle", 32'(busy), 32'd0);
      push_req(1'b0, 8'h10, 16'h0);
      drain();
      chk("post_flush_read", 32'(last_rdata), 32'h1234);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
